cdb_arbiter: RTL and testbench



---
 rtl/fcpu_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/cdb_arbiter.sv | 73 +++++++
 tb/tb_cdb_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fcpu_pkg.sv
// Shared widths and functional-unit indices for the CPU datapath, plus the
// round-robin pointer helper used by the CDB arbiter and issue arbitration.
package fcpu_pkg;

    localparam int RSV_ID_W    = 4;
    localparam int DATA_W      = 32;
    localparam int CDB_W       = RSV_ID_W + DATA_W;
    localparam int N_CDB_UNITS = 4;

    localparam int U_ALU = 0;
    localparam int U_BR  = 1;
    localparam int U_MEM = 2;
    localparam int U_FPU = 3;

    typedef logic [CDB_W-1:0] cdb_word_t;

    // The pointer wraps modulo the unit count, which need not be a power of two.
    function automatic int rr_wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// wins, wrapping back to the lowest requester when none sits above ptr.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx
);

    logic             hi_found;
    logic             lo_found;
    logic [PTR_W-1:0] hi_idx;
    logic [PTR_W-1:0] lo_idx;

    // Two searches in one pass: the lowest requester overall, and the lowest
    // requester at or above ptr; the latter takes precedence.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = 0; j < N; j++) begin
            if (req[j] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = PTR_W'(j);
            end
            if (req[j] && !hi_found && (PTR_W'(j) >= ptr)) begin
                hi_found = 1'b1;
                hi_idx   = PTR_W'(j);
            end
        end
        grant_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        grant = '0;
        for (int j = 0; j < N; j++) begin
            grant[j] = req[j] && (grant_idx == PTR_W'(j));
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one execution-unit result per cycle in
// round-robin order and broadcasts it from a register one cycle later.
module cdb_arbiter
    import fcpu_pkg::*;
#(
    parameter int N_UNITS = N_CDB_UNITS,
    parameter int CDB_W   = fcpu_pkg::CDB_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_UNITS*CDB_W-1:0] u_cdb,
    input  logic [N_UNITS-1:0]       u_valid,
    output logic [N_UNITS-1:0]       u_ready,
    output logic [CDB_W-1:0]         cdb,
    output logic                     cdb_valid,
    output logic [N_UNITS*16-1:0]    grant_cnt
);

    localparam int PTR_W = $clog2(N_UNITS);

    logic [PTR_W-1:0] rr_ptr;
    logic [N_UNITS-1:0] req;
    logic [N_UNITS-1:0] grant;
    logic [PTR_W-1:0] grant_idx;
    logic any_grant;
    logic [CDB_W-1:0] words [N_UNITS];
    logic [15:0] cnt [N_UNITS];

    // Masking requests during reset keeps producers' results pending.
    assign req       = rst ? '0 : u_valid;
    assign u_ready   = grant;
    assign any_grant = |grant;

    for (genvar k = 0; k < N_UNITS; k++) begin : g_unit
        assign words[k]              = u_cdb[k*CDB_W +: CDB_W];
        assign grant_cnt[k*16 +: 16] = cnt[k];
    end

    rr_arbiter #(
        .N     (N_UNITS),
        .PTR_W (PTR_W)
    ) u_rr (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb       <= '0;
            cdb_valid <= 1'b0;
            rr_ptr    <= '0;
        end else if (any_grant) begin
            cdb       <= words[grant_idx];
            cdb_valid <= 1'b1;
            rr_ptr    <= PTR_W'(rr_wrap_inc(int'(grant_idx), N_UNITS));
        end else begin
            cdb_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < N_UNITS; k++) begin
            if (rst) begin
                cnt[k] <= '0;
            end else if (grant[k]) begin
                cnt[k] <= cnt[k] + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a 4-unit instance scored through a queue of
// expected broadcasts, plus a 3-unit instance exercising non-power-of-two wrap.
module tb_cdb_arbiter;
    import fcpu_pkg::*;

    localparam int N  = 4;
    localparam int N3 = 3;
    localparam int NV = 24;

    typedef struct packed {
        logic             v;
        logic [CDB_W-1:0] w;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N*CDB_W-1:0]   u_cdb;
    logic [N-1:0]         u_valid = '0;
    logic [N-1:0]         u_ready;
    logic [CDB_W-1:0]     cdb;
    logic                 cdb_valid;
    logic [N*16-1:0]      grant_cnt;

    logic                 rst3 = 1'b1;
    logic [N3*CDB_W-1:0]  u_cdb3;
    logic [N3-1:0]        u_valid3 = '1;
    logic [N3-1:0]        u_ready3;
    logic [CDB_W-1:0]     cdb3;
    logic                 cdb_valid3;
    logic [N3*16-1:0]     grant_cnt3;

    exp_t                 exp_q [$];
    int                   n_checks = 0;
    int                   n_pass   = 0;
    logic [CDB_W-1:0]     unit_word [N];
    logic [CDB_W-1:0]     unit_word3 [N3];
    logic [CDB_W-1:0]     last_word = '0;
    logic [15:0]          exp_cnt [N];
    int                   k3 = 0;
    logic                 prev_g3 = 1'b0;

    logic                 tr [NV];
    logic [3:0]           tv [NV];
    int                   tw [NV];

    cdb_arbiter #(.N_UNITS(N), .CDB_W(CDB_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .u_cdb     (u_cdb),
        .u_valid   (u_valid),
        .u_ready   (u_ready),
        .cdb       (cdb),
        .cdb_valid (cdb_valid),
        .grant_cnt (grant_cnt)
    );

    cdb_arbiter #(.N_UNITS(N3), .CDB_W(CDB_W)) dut3 (
        .clk       (clk),
        .rst       (rst3),
        .u_cdb     (u_cdb3),
        .u_valid   (u_valid3),
        .u_ready   (u_ready3),
        .cdb       (cdb3),
        .cdb_valid (cdb_valid3),
        .grant_cnt (grant_cnt3)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // One cycle: drive at posedge+1, check combinational outputs before the
    // edge, then after the edge queue the broadcast expected next cycle.
    task automatic applyStimulus(input logic r, input logic [3:0] v, input int win);
        logic [N-1:0]  exp_ready;
        logic [N3-1:0] exp_ready3;
        rst  = r;
        rst3 = r;
        u_valid = v;
        #3;
        exp_ready  = (win >= 0) ? N'(1 << win) : '0;
        exp_ready3 = r ? '0 : N3'(1 << k3);
        checkOutput("u_ready", 64'(u_ready), 64'(exp_ready));
        checkOutput("grant_cnt", grant_cnt, {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]});
        checkOutput("u_ready_n3", 64'(u_ready3), 64'(exp_ready3));
        checkOutput("cdb_valid_n3", 64'(cdb_valid3), 64'(prev_g3));
        @(posedge clk);
        #1;
        if (r) begin
            last_word = '0;
            for (int k = 0; k < N; k++) exp_cnt[k] = '0;
            k3 = 0;
            prev_g3 = 1'b0;
        end else begin
            if (win >= 0) begin
                last_word = unit_word[win];
                exp_cnt[win] = exp_cnt[win] + 16'd1;
            end
            k3 = (k3 == N3 - 1) ? 0 : k3 + 1;
            prev_g3 = 1'b1;
        end
        exp_q.push_back('{v: (win >= 0), w: last_word});
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("cdb_valid", 64'(cdb_valid), 64'(e.v));
                checkOutput("cdb", 64'(cdb), 64'(e.w));
            end else if (cdb_valid === 1'b1) begin
                checkOutput("cdb_valid_unexpected", 64'(cdb_valid), 64'd0);
            end
        end
    end

    initial begin : stimulus
        unit_word[0]  = 36'hA_1111_0000;
        unit_word[1]  = 36'hB_2222_0001;
        unit_word[2]  = 36'h5_0000_002A;
        unit_word[3]  = 36'hC_3333_FFFF;
        unit_word3[0] = 36'h1_1111_1111;
        unit_word3[1] = 36'h2_2222_2222;
        unit_word3[2] = 36'h3_3333_3333;
        u_cdb  = {unit_word[3], unit_word[2], unit_word[1], unit_word[0]};
        u_cdb3 = {unit_word3[2], unit_word3[1], unit_word3[0]};
        for (int k = 0; k < N; k++) exp_cnt[k] = '0;

        // Reset, single requester, idle gap, pointer skip, reset mid-stream,
        // then full contention from reset.
        tr = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
               0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv = '{4'b0000, 4'b1111, 4'b0100, 4'b0100, 4'b0100, 4'b0000,
               4'b0000, 4'b1011, 4'b0001, 4'b1001, 4'b1001, 4'b0011,
               4'b0011, 4'b0011, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
               4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000};
        tw = '{-1, -1, 2, 2, 2, -1, -1, 3, 0, 3, 0, -1,
                0, 1, -1, 0, 1, 2, 3, 0, 1, 2, 3, -1};

        @(posedge clk);
        #1;
        for (int i = 0; i < NV; i++) begin
            if (i == 5) begin
                checkOutput("grant_cnt_u2_after3", 64'(grant_cnt[47:32]), 64'd3);
            end
            if (i == 23) begin
                checkOutput("grant_cnt_all2", grant_cnt, {4{16'd2}});
            end
            applyStimulus(tr[i], tv[i], tw[i]);
        end

        checkOutput("grant_cnt_n3_all3", 64'(grant_cnt3), 64'({3{16'd3}}));
        checkOutput("cdb_n3_last", 64'(cdb3), 64'(unit_word3[2]));
        repeat (2) @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
